// File: rtl/scroll_msg_pkg.sv
// Shared character codes, segment patterns and reset message for scroll_msg_display.
package scroll_msg_pkg;

  localparam logic [2:0] CH_H     = 3'b000;
  localparam logic [2:0] CH_E     = 3'b001;
  localparam logic [2:0] CH_L     = 3'b010;
  localparam logic [2:0] CH_O     = 3'b011;
  localparam logic [2:0] CH_BLANK = 3'b100;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int unsigned RstMsgLen = 5;
  localparam logic [0:RstMsgLen-1][2:0] RST_MSG = {CH_H, CH_E, CH_L, CH_L, CH_O};

  function automatic logic [2:0] rst_char(input int slot);
    logic [2:0] c;
    c = CH_BLANK;
    if (slot >= 0 && slot < RstMsgLen) c = RST_MSG[slot];
    return c;
  endfunction

  // Active-low segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg_of(input logic [2:0] code);
    logic [6:0] s;
    s = SEG_OFF;
    if (!code[2]) begin
      unique case (code[1:0])
        2'b00:   s = 7'b0001001;
        2'b01:   s = 7'b0000110;
        2'b10:   s = 7'b1000111;
        default: s = 7'b1000000;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/scroll_msg_display_dec.sv
// Combinational character-code to active-low 7-segment decoder (1xx = blank).
module msg_seg_dec
  import scroll_msg_pkg::*;
(
  input  logic [2:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg_of(code_i);
  end

endmodule

// File: rtl/scroll_msg_display.sv
// Scrolling message display over NUM_DIGITS 7-segment digits.
// Optional blink blanking enabled by defining SCROLL_MSG_BLINK_EN.
module scroll_msg_display
  import scroll_msg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned IDX_W      = $clog2(MSG_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    dir,
  input  logic                    step,
  input  logic                    load_valid,
  input  logic [IDX_W-1:0]        load_idx,
  input  logic [2:0]              load_char,
`ifdef SCROLL_MSG_BLINK_EN
  input  logic                    blink,
`endif
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [IDX_W-1:0]        offset,
  output logic                    tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  // Window decoded from the reset buffer at offset 0.
  function automatic logic [7*NUM_DIGITS-1:0] rst_hex();
    logic [7*NUM_DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      r[7*k +: 7] = seg_of(rst_char((int'(NUM_DIGITS) - 1 - k) % int'(MSG_LEN)));
    end
    return r;
  endfunction

  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]              offset_q, offset_d;
  logic [MSG_LEN-1:0][2:0]       msg_q;
  logic                          tick_q;
  logic [7*NUM_DIGITS-1:0]       hex_q, hex_d, seg_win;
  logic                          auto_step, step_now;
  logic                          blank_now;

  always_comb begin
    auto_step = run && (cnt_q == CntMax);
    step_now  = step || auto_step;
    cnt_d     = '0;
    if (run && !auto_step) cnt_d = cnt_q + 1'b1;
    offset_d  = offset_q;
    if (step_now) offset_d = dir ? offset_q - 1'b1 : offset_q + 1'b1;
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    localparam logic [IDX_W-1:0] Shift = IDX_W'(NUM_DIGITS - 1 - k);
    logic [IDX_W-1:0] slot;
    assign slot = offset_q + Shift;
    msg_seg_dec u_dec (
      .code_i (msg_q[slot]),
      .seg_o  (seg_win[7*k +: 7])
    );
  end

`ifdef SCROLL_MSG_BLINK_EN
  logic phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= 1'b0;
    else if (step_now) phase_q <= ~phase_q;
  end

  assign blank_now = blink && phase_q;
`else
  assign blank_now = 1'b0;
`endif

  always_comb begin
    hex_d = blank_now ? {NUM_DIGITS{SEG_OFF}} : seg_win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      offset_q <= '0;
      tick_q   <= 1'b0;
      hex_q    <= rst_hex();
      for (int i = 0; i < int'(MSG_LEN); i++) msg_q[i] <= rst_char(i);
    end else begin
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      tick_q   <= step_now;
      hex_q    <= hex_d;
      if (load_valid) msg_q[load_idx] <= load_char;
    end
  end

  assign hex    = hex_q;
  assign offset = offset_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_scroll_msg_display.sv
// Randomized self-checking bench for scroll_msg_display (TICK_DIV=4, 8 digits, 8 chars).
module tb_scroll_msg_display;

  localparam int ND = 8;
  localparam int ML = 8;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst, run, dir, step, load_valid;
  logic [2:0]    load_idx, load_char;
  logic          blink;
  logic [8*7-1:0] hex;
  logic [2:0]    offset;
  logic          tick;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int       m_buf[ML];
  int       m_off, m_cnt;
  bit       m_tick, m_phase;
  logic [8*7-1:0] m_hex;

  scroll_msg_display #(
    .NUM_DIGITS (ND),
    .MSG_LEN    (ML),
    .TICK_DIV   (TD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .dir        (dir),
    .step       (step),
    .load_valid (load_valid),
    .load_idx   (load_idx),
    .load_char  (load_char),
`ifdef SCROLL_MSG_BLINK_EN
    .blink      (blink),
`endif
    .hex        (hex),
    .offset     (offset),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int c);
    case (c)
      0:       return 7'b0001001;
      1:       return 7'b0000110;
      2:       return 7'b1000111;
      3:       return 7'b1000000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [8*7-1:0] ref_window(input bit blank);
    logic [8*7-1:0] r;
    for (int k = 0; k < ND; k++) r[7*k +: 7] = ref_seg(m_buf[(m_off + ND - 1 - k) % ML]);
    if (blank) r = '1;
    return r;
  endfunction

  task automatic model_reset();
    int msg[5] = '{0, 1, 2, 2, 3};
    for (int i = 0; i < ML; i++) m_buf[i] = (i < 5) ? msg[i] : 4;
    m_off = 0; m_cnt = 0; m_tick = 0; m_phase = 0;
    m_hex = ref_window(1'b0);
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [8*7-1:0] nh;
    bit auto_s, stp, bl;
`ifdef SCROLL_MSG_BLINK_EN
    bl = blink && m_phase;
`else
    bl = 0;
`endif
    nh = ref_window(bl);
    auto_s = run && (m_cnt == TD - 1);
    stp = step || auto_s;
    m_cnt = (run && !auto_s) ? m_cnt + 1 : 0;
    if (load_valid) m_buf[load_idx] = load_char;
    if (stp) m_off = dir ? (m_off + ML - 1) % ML : (m_off + 1) % ML;
    if (stp) m_phase = !m_phase;
    m_tick = stp;
    m_hex = nh;
  endtask

  task automatic check_outs(input string where);
    check_eq({where, ".offset"}, 64'(offset), 64'(m_off));
    check_eq({where, ".tick"}, 64'(tick), 64'(m_tick));
    check_eq({where, ".hex"}, 64'(hex), 64'(m_hex));
  endtask

  task automatic cycle(input bit r, input bit d, input bit s, input bit lv,
                       input int li, input int lc, input bit bl, input string where);
    run = r; dir = d; step = s; load_valid = lv;
    load_idx = 3'(li); load_char = 3'(lc); blink = bl;
    model_edge();
    @(negedge clk);
    check_outs(where);
  endtask

  task automatic do_reset(input string where);
    rst = 1'b1;
    model_reset();
    #1;
    check_outs(where);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int off0;
    rst = 1'b1; run = 0; dir = 0; step = 0; load_valid = 0;
    load_idx = '0; load_char = '0; blink = 0;
    model_reset();
    @(negedge clk);
    check_outs("reset");
    check_eq("reset.hex7_H", 64'(hex[55:49]), 64'(7'b0001001));
    check_eq("reset.hex0_blank", 64'(hex[6:0]), 64'(7'h7F));
    rst = 1'b0;

    // Three manual steps to offset 3, then asynchronous reset mid-run
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0, 0, "step_fwd");
    check_eq("pre_reset.offset3", 64'(offset), 64'd3);
    run = 1'b1;
    #2;
    do_reset("async_reset");

    // Auto scroll one full revolution
    for (int i = 0; i < 34; i++) cycle(1, 0, 0, 0, 0, 0, 0, "auto");

    // Reverse wrap from offset 0
    do_reset("reset2");
    cycle(0, 1, 1, 0, 0, 0, 0, "rev_wrap");
    check_eq("rev_wrap.offset7", 64'(offset), 64'd7);
    cycle(0, 1, 0, 0, 0, 0, 0, "rev_wrap_hex");
    check_eq("rev_wrap.hex7_blank", 64'(hex[55:49]), 64'(7'h7F));
    check_eq("rev_wrap.hex6_H", 64'(hex[48:42]), 64'(7'b0001001));

    // Collision: manual step on the auto-step cycle
    do_reset("reset3");
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0, "coll_pre");
    off0 = offset;
    cycle(1, 0, 1, 0, 0, 0, 0, "collision");
    check_eq("collision.delta1", 64'(offset), 64'((off0 + 1) % ML));

    // Load during step
    do_reset("reset4");
    cycle(0, 0, 1, 1, 7, 3, 0, "load_step");
    cycle(0, 0, 0, 0, 0, 0, 0, "load_step_hex");
    check_eq("load_step.hex1_O", 64'(hex[13:7]), 64'(7'b1000000));

    // Pause
    for (int i = 0; i < 100; i++) cycle(0, 1, 0, 0, 0, 0, 0, "pause");

    // Randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_reset");
      end else begin
        cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), 1'($urandom), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
